vec_mem_sequencer: RTL and testbench

VEC_MEM_SEQUENCER -- requirements
Module: vec_mem_sequencer

---
 rtl/vms_pkg.sv | 14 +
 rtl/vms_obuf.sv | 52 +++++
 rtl/vec_mem_sequencer.sv | 165 ++++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vms_pkg.sv
// Shared types and constants for the vector memory sequencer.
package vms_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } vms_state_e;

    localparam int unsigned OBUF_DEPTH = 2;
    localparam int unsigned OBUF_CNT_W = 2;

endpackage

// File: rtl/vms_obuf.sv
// Two-entry load-data FIFO; an empty FIFO passes a pushed word straight to the head.
module vms_obuf
    import vms_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty,
    output logic [OBUF_CNT_W-1:0] count
);

    logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [OBUF_CNT_W-1:0] count_q;
    logic                  wr_store;
    logic                  rd_take;

    assign empty      = (count_q == '0);
    assign full       = (count_q == OBUF_CNT_W'(OBUF_DEPTH));
    assign count      = count_q;
    assign head_valid = ~empty | push;
    assign head_data  = empty ? push_data : mem_q[rd_ptr_q];

    // A word pushed into an empty FIFO and popped in the same cycle is never stored.
    assign wr_store = push & ~(empty & pop);
    assign rd_take  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (wr_store) wr_ptr_q <= ~wr_ptr_q;
            if (rd_take)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + OBUF_CNT_W'(wr_store) - OBUF_CNT_W'(rd_take);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_store) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/vec_mem_sequencer.sv
// Strided vector load/store sequencer driving a 1-cycle-latency memory.
// Define VMS_STRIDE_EN to honour req_stride; otherwise the stride is one word.
module vec_mem_sequencer
    import vms_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [ADDR_WIDTH-1:0] req_base,
    input  logic [ADDR_WIDTH-1:0] req_stride,
    input  logic [CNT_WIDTH-1:0]  req_count,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic                  ld_valid,
    input  logic                  ld_ready,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data_in
);

    vms_state_e            state_q;
    vms_state_e            state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] stride_sel;
    logic [CNT_WIDTH-1:0]  rem_q;
    logic                  inflight_q;
    logic                  req_hs;
    logic                  issue;
    logic                  words_left;
    logic                  rd_room;
    logic                  load_drained;
    logic                  obuf_push;
    logic                  obuf_pop;
    logic                  obuf_full;
    logic                  obuf_empty;
    logic                  obuf_head_valid;
    logic [DATA_WIDTH-1:0] obuf_head_data;
    logic [OBUF_CNT_W-1:0] obuf_count;

`ifdef VMS_STRIDE_EN
    assign stride_sel = req_stride;
`else
    logic stride_unused;
    assign stride_unused = ^req_stride;
    assign stride_sel    = ADDR_WIDTH'(DATA_WIDTH / 8);
`endif

    assign req_hs     = req_valid & req_ready;
    assign issue      = rd_en | wr_en;
    assign words_left = (rem_q != '0);

    // Reads returning while in reset are dropped before they reach the buffer.
    assign obuf_push = inflight_q & ~rst;
    assign ld_valid  = obuf_head_valid & ~rst;
    assign ld_data   = obuf_head_data;
    assign obuf_pop  = ld_valid & ld_ready;

    // Buffer slots plus outstanding reads never exceed the FIFO depth.
    assign rd_room = ((obuf_count + OBUF_CNT_W'(inflight_q)) < OBUF_CNT_W'(OBUF_DEPTH)) & ~obuf_full;

    // Last word leaves the buffer this cycle (or it is already empty) with nothing outstanding.
    assign load_drained = ~words_left & ~inflight_q &
                          (obuf_empty | ((obuf_count == OBUF_CNT_W'(1)) & obuf_pop));

    assign rd_addr    = addr_q;
    assign wr_addr    = addr_q;
    assign wr_data_in = st_data;

    vms_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk        (clk),
        .rst        (rst),
        .push       (obuf_push),
        .push_data  (rd_data_out),
        .pop        (obuf_pop),
        .head_valid (obuf_head_valid),
        .head_data  (obuf_head_data),
        .full       (obuf_full),
        .empty      (obuf_empty),
        .count      (obuf_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        st_ready  = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_count == '0) state_d = DONE;
                    else if (req_is_store) state_d = STORE;
                    else state_d = LOAD;
                end
            end
            LOAD: begin
                rd_en = words_left & rd_room;
                if (load_drained) state_d = DONE;
            end
            STORE: begin
                st_ready = words_left;
                wr_en    = st_valid & words_left;
                if (wr_en && (rem_q == CNT_WIDTH'(1))) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            req_ready = 1'b0;
            rd_en     = 1'b0;
            wr_en     = 1'b0;
            st_ready  = 1'b0;
            done      = 1'b0;
        end
    end

    // Address, stride and word count for the active request.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            stride_q   <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            if (req_hs) begin
                addr_q   <= req_base;
                stride_q <= stride_sel;
                rem_q    <= req_count;
            end else if (issue) begin
                addr_q <= addr_q + stride_q;
                rem_q  <= rem_q - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Scoreboard bench for vec_mem_sequencer: directed load/store/reset scenarios.
module tb_vec_mem_sequencer;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 8;
`ifdef VMS_STRIDE_EN
    localparam bit STRIDE_EN = 1'b1;
`else
    localparam bit STRIDE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_is_store;
    logic [AW-1:0] req_base, req_stride;
    logic [CW-1:0] req_count;
    logic          st_valid, st_ready;
    logic [DW-1:0] st_data;
    logic          ld_valid, ld_ready;
    logic [DW-1:0] ld_data;
    logic          done;
    logic          rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data_out, wr_data_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [AW-1:0] q_rd[$];
    logic [DW-1:0] q_ld[$];
    logic [AW-1:0] q_wa[$];
    logic [DW-1:0] q_wd[$];

    int w_first_ldv, w_first_rd, w_last_rd, w_rd_cnt, w_wr_cnt, w_last_wr, w_done_c, w_done_at, w_rdy_at;
    int hs;

    vec_mem_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_base(req_base), .req_stride(req_stride), .req_count(req_count),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_out(rd_data_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data_in(wr_data_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    function automatic logic [DW-1:0] sdat(input int i);
        case (i)
            0:       return 64'h1111_2222_3333_4444;
            1:       return 64'hDEAD_BEEF_0BAD_F00D;
            default: return 64'h0123_4567_89AB_CDEF;
        endcase
    endfunction

    function automatic logic [AW-1:0] eff_stride(input logic [AW-1:0] s);
        return STRIDE_EN ? s : AW'(DW / 8);
    endfunction

    // Memory model: read data appears one cycle after the read is issued.
    always @(posedge clk) rd_data_out <= mdata(rd_addr);

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read, write or load word.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                if (q_rd.size() == 0) check("rd_unexpected", 64'(rd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                else check("rd_addr", 64'(rd_addr), 64'(q_rd.pop_front()));
            end
            if (ld_valid && ld_ready) begin
                if (q_ld.size() == 0) check("ld_unexpected", ld_data, ~ld_data);
                else check("ld_data", ld_data, q_ld.pop_front());
            end
            if (wr_en) begin
                if (q_wa.size() == 0) check("wr_unexpected", 64'(wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    check("wr_addr", 64'(wr_addr), 64'(q_wa.pop_front()));
                    check("wr_data", wr_data_in, q_wd.pop_front());
                end
            end
            if (rd_en && wr_en) check("rd_wr_exclusive", 64'(rd_en & wr_en), 64'd0);
        end
    end

    task automatic push_load(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int n);
        for (int i = 0; i < n; i++) begin
            q_rd.push_back(base + AW'(i) * eff_stride(stride));
            q_ld.push_back(mdata(base + AW'(i) * eff_stride(stride)));
        end
    endtask

    task automatic push_store(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int n);
        for (int i = 0; i < n; i++) begin
            q_wa.push_back(base + AW'(i) * eff_stride(stride));
            q_wd.push_back(sdat(i));
        end
    endtask

    task automatic handshake(input logic is_store, input logic [AW-1:0] base,
                             input logic [AW-1:0] stride, input logic [CW-1:0] count);
        bit got = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_is_store = is_store;
        req_base = base; req_stride = stride; req_count = count;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                hs = cyc;
            end
        end
        if (!got) check("req_handshake_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        st_valid  = 1'b0;
        st_data   = sdat(0);
    endtask

    // Observe n cycles from the cycle after the handshake, optionally driving a toggling store stream.
    task automatic window(input int n, input bit drv_st);
        int widx = 0;
        w_first_ldv = -1; w_first_rd = -1; w_last_rd = -1; w_rd_cnt = 0;
        w_wr_cnt = 0; w_last_wr = -1; w_done_c = 0; w_done_at = -1; w_rdy_at = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (ld_valid && w_first_ldv < 0) w_first_ldv = cyc;
            if (rd_en) begin
                if (w_first_rd < 0) w_first_rd = cyc;
                w_last_rd = cyc;
                w_rd_cnt++;
            end
            if (wr_en) begin
                w_wr_cnt++;
                w_last_wr = cyc;
            end
            if (done) begin
                w_done_c++;
                w_done_at = cyc;
            end
            if (req_ready && w_rdy_at < 0) w_rdy_at = cyc;
            if (st_valid && st_ready) widx++;
            @(posedge clk); #1;
            if (drv_st) begin
                st_valid = (widx < 3) ? ~st_valid : 1'b0;
                st_data  = sdat(widx);
            end
        end
        st_valid = 1'b0;
    endtask

    task automatic check_rst_outputs(input string name);
        check(name, 64'({rd_en, wr_en, ld_valid, st_ready, done, req_ready}), 64'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
        req_base = '0; req_stride = '0; req_count = '0;
        st_valid = 1'b0; st_data = '0; ld_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_rst_outputs("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(req_ready), 64'd1);

        // Unit-stride load, consumer always ready.
        ld_ready = 1'b1;
        push_load(32'h41FF_F000, 32'd8, 4);
        handshake(1'b0, 32'h41FF_F000, 32'd8, 8'd4);
        window(12, 1'b0);
        check("load_first_rd_cycle", 64'(w_first_rd), 64'(hs + 1));
        check("load_rd_back_to_back", 64'(w_last_rd - w_first_rd), 64'd3);
        check("load_first_ldv_cycle", 64'(w_first_ldv), 64'(hs + 2));
        check("load_done_pulses", 64'(w_done_c), 64'd1);
        check("load_queues_empty", 64'(q_rd.size() + q_ld.size()), 64'd0);

        // Load with back-pressure: issue stops at two outstanding words.
        ld_ready = 1'b0;
        push_load(32'h0000_3000, 32'd8, 4);
        handshake(1'b0, 32'h0000_3000, 32'd8, 8'd4);
        window(10, 1'b0);
        check("bp_reads_issued", 64'(w_rd_cnt), 64'd2);
        check("bp_no_done", 64'(w_done_c), 64'd0);
        ld_ready = 1'b1;
        window(12, 1'b0);
        check("bp_reads_resumed", 64'(w_rd_cnt), 64'd2);
        check("bp_done_pulses", 64'(w_done_c), 64'd1);
        check("bp_all_delivered", 64'(q_rd.size() + q_ld.size()), 64'd0);

        // Store with st_valid toggling.
        push_store(32'h41FF_F100, 32'd16, 3);
        handshake(1'b1, 32'h41FF_F100, 32'd16, 8'd3);
        window(12, 1'b1);
        check("store_writes", 64'(w_wr_cnt), 64'd3);
        check("store_no_reads", 64'(w_rd_cnt), 64'd0);
        check("store_done_after_last_wr", 64'(w_done_at), 64'(w_last_wr + 1));
        check("store_done_pulses", 64'(w_done_c), 64'd1);
        check("store_queue_empty", 64'(q_wa.size()), 64'd0);

        // Zero-length request.
        handshake(1'b0, 32'h0000_5000, 32'd8, 8'd0);
        window(4, 1'b0);
        check("zero_no_access", 64'(w_rd_cnt + w_wr_cnt), 64'd0);
        check("zero_done_cycle", 64'(w_done_at), 64'(hs + 1));
        check("zero_ready_cycle", 64'(w_rdy_at), 64'(hs + 2));

        // Address wrap at the top of the address space.
        push_load(32'hFFFF_FFF8, 32'd8, 2);
        handshake(1'b0, 32'hFFFF_FFF8, 32'd8, 8'd2);
        window(10, 1'b0);
        check("wrap_done_pulses", 64'(w_done_c), 64'd1);
        check("wrap_queues_empty", 64'(q_rd.size() + q_ld.size()), 64'd0);

        // Reset two words into an 8-word load.
        push_load(32'h0000_1000, 32'd8, 8);
        handshake(1'b0, 32'h0000_1000, 32'd8, 8'd8);
        window(3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_rst_outputs("midload_reset_outputs");
        @(posedge clk); #1;
        q_rd.delete(); q_ld.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midload_reset", 64'(req_ready), 64'd1);
        check("no_stale_ld_valid", 64'(ld_valid), 64'd0);

        push_load(32'h0000_2000, 32'd8, 2);
        handshake(1'b0, 32'h0000_2000, 32'd8, 8'd2);
        window(10, 1'b0);
        check("post_reset_done_pulses", 64'(w_done_c), 64'd1);
        check("post_reset_queues_empty", 64'(q_rd.size() + q_ld.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
